// File: rtl/alu_seq_if.sv
// alu_seq_if: handshake/operand/result bundle for alu_seq.
//   Operand channel : in_valid, in_ready, n1, n2, operator, use_acc
//   Result channel  : out_valid, out_ready, result, CCR ({N,Z,V,C}), busy
//   master : operand sequencer / result consumer side
//   slave  : the ALU itself
interface alu_seq_if #(
   parameter int WIDTH = 4
);
   logic             in_valid;
   logic             in_ready;
   logic [WIDTH-1:0] n1;
   logic [WIDTH-1:0] n2;
   logic [2:0]       operator;
   logic             use_acc;
   logic             out_valid;
   logic             out_ready;
   logic [WIDTH-1:0] result;
   logic [3:0]       CCR;
   logic             busy;

   modport master (
      output in_valid, n1, n2, operator, use_acc, out_ready,
      input  in_ready, out_valid, result, CCR, busy
   );

   modport slave (
      input  in_valid, n1, n2, operator, use_acc, out_ready,
      output in_ready, out_valid, result, CCR, busy
   );
endinterface

// File: rtl/alu_seq.sv
// alu_seq: registered ALU with valid/ready handshake, {N,Z,V,C} condition
// codes and an accumulator that can replace operand A.
//   clk   : rising-edge clock
//   reset : synchronous, active-high
//   bus   : alu_seq_if.slave (operands/op in, result/CCR/busy out)
// Opcodes: 000 ADD, 001 SUB, 010 AND, 011 OR, 100 XOR, 101 SHL1, 110 SHR1,
//          111 MUL.
// Build option: define ALU_MUL_EN for the multi-cycle shift-add multiply;
// without it opcode 111 completes in one cycle with result 0, CCR 4'b0100.
module alu_seq #(
   parameter int WIDTH = 4
) (
   input logic      clk,
   input logic      reset,
   alu_seq_if.slave bus
);
`ifdef ALU_MUL_EN
   localparam int CNT_W = $clog2(WIDTH) + 1;
`endif

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_HOLD = 2'd1
`ifdef ALU_MUL_EN
      , S_MUL = 2'd2
`endif
   } state_t;

   state_t           state, state_n;
   logic [WIDTH-1:0] result_q, acc, a_op, res_c;
   logic [WIDTH:0]   sum_c;
   logic [3:0]       ccr_q;
   logic             c_c, v_c;
   logic             in_ready, xfer, load;

`ifdef ALU_MUL_EN
   logic [2*WIDTH-1:0] mcand, prod, prod_n;
   logic [WIDTH-1:0]   mplier;
   logic [CNT_W-1:0]   cnt;
   logic               mul_start, mul_step, mul_last;
`endif

   assign in_ready = !reset && ((state == S_IDLE) || (state == S_HOLD && bus.out_ready));
   assign xfer     = bus.in_valid && in_ready;
   // acc is read before the transfer edge writes it, so chaining sees the previous result
   assign a_op     = bus.use_acc ? acc : bus.n1;

   // single-cycle datapath; opcode 111 falls through to zero result, C=V=0
   always_comb begin
      sum_c = '0;
      res_c = '0;
      c_c   = 1'b0;
      v_c   = 1'b0;
      case (bus.operator)
         3'b000: begin
            sum_c = {1'b0, a_op} + {1'b0, bus.n2};
            res_c = sum_c[WIDTH-1:0];
            c_c   = sum_c[WIDTH];
            v_c   = (a_op[WIDTH-1] == bus.n2[WIDTH-1]) && (res_c[WIDTH-1] != a_op[WIDTH-1]);
         end
         3'b001: begin
            res_c = a_op - bus.n2;
            c_c   = a_op < bus.n2;
            v_c   = (a_op[WIDTH-1] != bus.n2[WIDTH-1]) && (res_c[WIDTH-1] != a_op[WIDTH-1]);
         end
         3'b010: res_c = a_op & bus.n2;
         3'b011: res_c = a_op | bus.n2;
         3'b100: res_c = a_op ^ bus.n2;
         3'b101: begin
            res_c = {a_op[WIDTH-2:0], 1'b0};
            c_c   = a_op[WIDTH-1];
            v_c   = a_op[WIDTH-1] ^ a_op[WIDTH-2];
         end
         3'b110: begin
            res_c = {1'b0, a_op[WIDTH-1:1]};
            c_c   = a_op[0];
         end
         default: ;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) state <= S_IDLE;
      else       state <= state_n;
   end

   always_comb begin
      state_n = state;
      load    = 1'b0;
`ifdef ALU_MUL_EN
      mul_start = 1'b0;
      mul_step  = 1'b0;
      mul_last  = 1'b0;
`endif
      case (state)
         S_IDLE: ;
         S_HOLD: if (bus.out_ready) state_n = S_IDLE;
`ifdef ALU_MUL_EN
         S_MUL: begin
            mul_step = 1'b1;
            if (cnt == CNT_W'(WIDTH - 1)) begin
               mul_last = 1'b1;
               state_n  = S_HOLD;
            end
         end
`endif
         default: state_n = S_IDLE;
      endcase
      // a transfer overrides the HOLD->IDLE exit so back-to-back ops stay in HOLD
      if (xfer) begin
`ifdef ALU_MUL_EN
         if (bus.operator == 3'b111) begin
            mul_start = 1'b1;
            state_n   = S_MUL;
         end else begin
            load    = 1'b1;
            state_n = S_HOLD;
         end
`else
         load    = 1'b1;
         state_n = S_HOLD;
`endif
      end
   end

`ifdef ALU_MUL_EN
   assign prod_n = prod + (mplier[0] ? mcand : '0);
`endif

   always_ff @(posedge clk) begin
      if (reset) begin
         result_q <= '0;
         ccr_q    <= '0;
         acc      <= '0;
`ifdef ALU_MUL_EN
         cnt      <= '0;
`endif
      end else begin
         if (load) begin
            result_q <= res_c;
            ccr_q    <= {res_c[WIDTH-1], res_c == '0, v_c, c_c};
            acc      <= res_c;
         end
`ifdef ALU_MUL_EN
         if (mul_start) begin
            mcand  <= {{WIDTH{1'b0}}, a_op};
            mplier <= bus.n2;
            prod   <= '0;
            cnt    <= '0;
         end
         if (mul_step) begin
            prod   <= prod_n;
            mcand  <= mcand << 1;
            mplier <= mplier >> 1;
            cnt    <= cnt + 1'b1;
            if (mul_last) begin
               result_q <= prod_n[WIDTH-1:0];
               ccr_q    <= {prod_n[WIDTH-1], prod_n[WIDTH-1:0] == '0,
                            prod_n[2*WIDTH-1:WIDTH] != '0, prod_n[2*WIDTH-1:WIDTH] != '0};
               acc      <= prod_n[WIDTH-1:0];
            end
         end
`endif
      end
   end

   assign bus.in_ready  = in_ready;
   assign bus.out_valid = (state == S_HOLD);
   assign bus.result    = result_q;
   assign bus.CCR       = ccr_q;
`ifdef ALU_MUL_EN
   assign bus.busy      = (state == S_MUL);
`else
   assign bus.busy      = 1'b0;
`endif
endmodule

// File: tb/tb_alu_seq.sv
// tb_alu_seq: directed self-checking bench for alu_seq (WIDTH=4).
// Inputs change and outputs are sampled 1 time unit after each rising edge.
module tb_alu_seq;
   logic clk;
   logic reset;
   int   n_total;
   int   n_pass;

   alu_seq_if #(.WIDTH(4)) bus ();

   alu_seq #(.WIDTH(4)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
      n_total++;
      assert (obs === exp) n_pass++;
      else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // present one operation, require it to be accepted at the next edge
   task automatic xfer(input string tag, input logic [2:0] op, input logic [3:0] a,
                       input logic [3:0] b, input logic ua);
      bus.in_valid = 1'b1;
      bus.operator = op;
      bus.n1       = a;
      bus.n2       = b;
      bus.use_acc  = ua;
      #1;
      chk({tag, "_rdy"}, bus.in_ready, 1);
      tick();
      bus.in_valid = 1'b0;
   endtask

   task automatic chk_out(input string tag, input logic [3:0] res, input logic [3:0] ccr);
      chk({tag, "_ov"}, bus.out_valid, 1);
      chk({tag, "_res"}, bus.result, res);
      chk({tag, "_ccr"}, bus.CCR, ccr);
   endtask

   initial begin
      n_total       = 0;
      n_pass        = 0;
      reset         = 1'b1;
      bus.in_valid  = 1'b0;
      bus.n1        = '0;
      bus.n2        = '0;
      bus.operator  = '0;
      bus.use_acc   = 1'b0;
      bus.out_ready = 1'b1;
      tick();
      tick();
      chk("rst_ov", bus.out_valid, 0);
      chk("rst_res", bus.result, 0);
      chk("rst_ccr", bus.CCR, 0);
      chk("rst_busy", bus.busy, 0);
      chk("rst_inrdy", bus.in_ready, 0);
      reset = 1'b0;
      #1;
      chk("post_rst_inrdy", bus.in_ready, 1);

`ifdef ALU_MUL_EN
      // reset during a multiply discards it
      xfer("mulrst", 3'b111, 4'b0101, 4'b0011, 1'b0);
      chk("mulrst_busy", bus.busy, 1);
      tick();
      reset = 1'b1;
      tick();
      chk("mulrst_ov", bus.out_valid, 0);
      chk("mulrst_res", bus.result, 0);
      chk("mulrst_ccr", bus.CCR, 0);
      chk("mulrst_busy0", bus.busy, 0);
      reset = 1'b0;
      #1;
      chk("mulrst_inrdy", bus.in_ready, 1);
      for (int i = 0; i < 6; i++) tick();
      chk("mulrst_noout", bus.out_valid, 0);
`endif

      // ADD overflow, then carry-out wrap to zero, back-to-back
      xfer("add1", 3'b000, 4'b0111, 4'b0001, 1'b0);
      chk_out("add1", 4'b1000, 4'b1010);
      xfer("add2", 3'b000, 4'b1111, 4'b0001, 1'b0);
      chk_out("add2", 4'b0000, 4'b0101);

      // SUB borrow, then SUB signed overflow
      xfer("sub1", 3'b001, 4'b0010, 4'b0101, 1'b0);
      chk_out("sub1", 4'b1101, 4'b1001);
      xfer("sub2", 3'b001, 4'b1000, 4'b0001, 1'b0);
      chk_out("sub2", 4'b0111, 4'b0010);

      // accumulator chain, no bubble; n1 must be ignored when use_acc=1
      xfer("acc1", 3'b000, 4'b0011, 4'b0001, 1'b0);
      chk_out("acc1", 4'b0100, 4'b0000);
      xfer("acc2", 3'b000, 4'b1111, 4'b0010, 1'b1);
      chk_out("acc2", 4'b0110, 4'b0000);
      tick();
      chk("acc_drop_ov", bus.out_valid, 0);

      // logic ops and shifts
      xfer("and", 3'b010, 4'b1100, 4'b1010, 1'b0);
      chk_out("and", 4'b1000, 4'b1000);
      xfer("or", 3'b011, 4'b0000, 4'b0000, 1'b0);
      chk_out("or", 4'b0000, 4'b0100);
      xfer("shl", 3'b101, 4'b1011, 4'b0000, 1'b0);
      chk_out("shl", 4'b0110, 4'b0011);
      xfer("shr", 3'b110, 4'b1001, 4'b0000, 1'b0);
      chk_out("shr", 4'b0100, 4'b0001);
      tick();

      // backpressure: result held, new request ignored
      bus.out_ready = 1'b0;
      xfer("bp", 3'b100, 4'b1010, 4'b0110, 1'b0);
      chk_out("bp", 4'b1100, 4'b1000);
      bus.in_valid = 1'b1;
      bus.operator = 3'b000;
      bus.n1       = 4'b0001;
      bus.n2       = 4'b0001;
      bus.use_acc  = 1'b0;
      for (int i = 0; i < 3; i++) begin
         #1;
         chk("bp_inrdy", bus.in_ready, 0);
         tick();
         chk_out("bp_hold", 4'b1100, 4'b1000);
      end
      bus.in_valid  = 1'b0;
      bus.out_ready = 1'b1;
      tick();
      chk("bp_drop_ov", bus.out_valid, 0);
      // acc still holds the XOR result
      xfer("bp_acc", 3'b000, 4'b0000, 4'b0000, 1'b1);
      chk_out("bp_acc", 4'b1100, 4'b1000);
      tick();

`ifdef ALU_MUL_EN
      xfer("mul", 3'b111, 4'b1111, 4'b1111, 1'b0);
      for (int i = 0; i < 4; i++) begin
         chk("mul_busy", bus.busy, 1);
         chk("mul_ov0", bus.out_valid, 0);
         chk("mul_inrdy", bus.in_ready, 0);
         tick();
      end
      chk("mul_busy0", bus.busy, 0);
      chk_out("mul", 4'b0001, 4'b0011);
      xfer("mulacc", 3'b000, 4'b0000, 4'b0010, 1'b1);
      chk_out("mulacc", 4'b0011, 4'b0000);
`else
      xfer("mul", 3'b111, 4'b1111, 4'b1111, 1'b0);
      chk("mul_busy", bus.busy, 0);
      chk_out("mul", 4'b0000, 4'b0100);
      xfer("mulacc", 3'b000, 4'b0000, 4'b0011, 1'b1);
      chk_out("mulacc", 4'b0011, 4'b0000);
`endif
      tick();
      chk("end_ov", bus.out_valid, 0);

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end
endmodule

// File: doc/alu_seq.md
Name: alu_seq

Overview:
Parametrised, registered successor to the 4-bit combinational ALU. It accepts operand pairs over a valid/ready handshake and registers the result plus an extended condition-code register, {N,Z,V,C}. It also keeps an accumulator that can stand in for operand A, and supports a multi-cycle shift-add multiply. It sits between the operand sequencer and the result bus of the datapath.

Parameters:
WIDTH, 4, operand/result width in bits (>=2)
CNT_W, $clog2(WIDTH)+1, multiply step-counter width (derived, not overridden)

Ports:
clk  input  1  rising-edge clock
reset  input  1  synchronous, active-high reset
in_valid  input  1  operands/op presented
in_ready  output  1  block can accept a transaction this cycle
n1  input  WIDTH  operand A (ignored when use_acc=1)
n2  input  WIDTH  operand B
operator  input  3  operation select
use_acc  input  1  1: operand A = accumulator
out_valid  output  1  result/CCR valid
out_ready  input  1  consumer takes result
result  output  WIDTH  registered result
CCR  output  4  {N,Z,V,C} registered flags
busy  output  1  high while multiply in progress

Behaviour:
- Reset (sync, reset=1 at clk edge): state=IDLE; result=0, CCR=0, acc=0, out_valid=0, busy=0. Reset aborts an in-flight multiply; no output is produced for it. in_ready=0 during the reset cycle.
- States:
  - IDLE: waits for a transfer.
  - MUL: shift-add in progress.
  - HOLD: out_valid=1, waiting for out_ready.
- in_ready = (state==IDLE) || (state==HOLD && out_ready). Transfer = in_valid && in_ready.
- Single-cycle ops: on transfer, result/CCR/acc are written at that edge, out_valid=1 next cycle (latency 1), state=HOLD. Back-to-back transfers at full throughput when out_ready stays high.
- Opcodes:
  - 000 ADD: C=carry out, V=signed overflow.
  - 001 SUB (A-B): C=borrow (A<B unsigned), V=signed overflow.
  - 010 AND, 011 OR, 100 XOR: C=0, V=0.
  - 101 SHL by 1: C=A[W-1], V=A[W-1]^A[W-2].
  - 110 SHR logical by 1: C=A[0], V=0.
  - 111 MUL: see Optional Feature.
- N=result[W-1] and Z=(result==0) for every op. All arithmetic is mod 2^WIDTH.
- acc is updated with result on every completed op. use_acc samples acc as it stands at the transfer edge, so a chained op uses the previous result.
- MUL (unsigned): on transfer, state=MUL, busy=1, in_ready=0. Processes one multiplier bit per cycle for WIDTH cycles into a 2*WIDTH product. On the final step, result = product[W-1:0], C=V=(product[2W-1:W]!=0), then state=HOLD. out_valid rises exactly WIDTH+1 cycles after the transfer edge.
- HOLD with out_ready=0: result/CCR/out_valid are held stable and in_ready=0. out_ready=1 with no new transfer: out_valid=0 next cycle, state=IDLE. out_ready=1 with a simultaneous transfer: new result replaces the old, out_valid stays 1.
- in_valid while in_ready=0: ignored. The source must hold its values until accepted.
- Unknown or unsupported op: never stalls the block.

Optional Feature:
Macro ALU_MUL_EN.
- Defined: opcode 111 performs the multi-cycle multiply above, with the MUL state and counter present.
- Undefined: no MUL state or counter is synthesised and busy is tied to 0. Opcode 111 completes in one cycle with result=0 and CCR=4'b0100 (Z only); acc is set to 0.

Test Plan:
- Reset mid-MUL (ALU_MUL_EN, WIDTH=4): start 0101*0011, assert reset on cycle 2 -> next cycle out_valid=0, result=0, CCR=0, in_ready=1 after reset is released.
- ADD 0111+0001, WIDTH=4, out_ready=1 -> one cycle later result=1000, CCR N=1 Z=0 V=1 C=0. Then ADD 1111+0001 -> result=0000, CCR=0101.
- SUB 0010-0101 -> result=1101, C=1 (borrow), N=1, V=0. Then SUB 1000-0001 -> result=0111, V=1, C=0.
- Accumulator chain: ADD 0011+0001 (acc=0100), then use_acc=1 ADD n2=0010 issued back-to-back -> results 0100 then 0110 on consecutive cycles, no bubble.
- Backpressure: XOR 1010^0110 with out_ready=0 for 3 cycles -> result=1100 held stable, in_ready=0, a new in_valid is ignored. out_ready=1 -> out_valid drops next cycle.
- MUL 1111*1111 (ALU_MUL_EN) -> out_valid exactly 5 cycles after transfer, busy=1 for 4 cycles, result=0001, C=V=1. Without the macro: same stimulus -> result=0000, CCR=0100 after 1 cycle.
